// File: rtl/expr_pkg.sv
// Shared types and constants for the left-to-right expression sequencer.
package expr_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int COUNT_W_DEF = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EXEC,
    DONE
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational add/subtract unit; results wrap modulo 2^WIDTH.
module alu
  import expr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             h,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = (h == OP_SUB) ? (a - b) : (a + b);
  end

endmodule

// File: rtl/expr_sequencer.sv
// Evaluates a stream of operand tokens strictly left to right through a
// registered-input ALU, one operand every two cycles after the first.
module expr_sequencer
  import expr_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [COUNT_W-1:0] out_count
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_h;
  logic               last_q;
  logic [COUNT_W-1:0] count;

  alu #(.WIDTH(WIDTH)) u_alu (
    .h (alu_h),
    .a (alu_a),
    .b (alu_b),
    .y (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = last_q ? DONE : ACCUM;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operands are captured on accept and stay untouched through EXEC,
  // so the combinational result is stable when acc samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      count  <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_h  <= OP_ADD;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= in_data;
            count <= COUNT_W'(1);
          end
        end
        ACCUM: begin
          if (in_valid) begin
            alu_a  <= acc;
            alu_b  <= in_data;
            alu_h  <= in_op;
            last_q <= in_last;
            count  <= (count == '1) ? count : count + COUNT_W'(1);
          end
        end
        EXEC: begin
          acc <= alu_y;
        end
        default: ;
      endcase
    end
  end

  assign out_result = acc;
  assign out_count  = count;

endmodule

// File: tb/tb_expr_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and randomized expressions scored against an arithmetic reference.
module tb_expr_sequencer;
  import expr_pkg::*;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_op = 1'b0;
  logic          in_last = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_result;
  logic [CW-1:0] out_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  expr_sequencer #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               n;
    logic [7:0]       ops;
    logic [7:0][W-1:0] data;
    int               hold;
    logic [W-1:0]     exp_res;
    logic [CW-1:0]    exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one token; caller must be at a falling edge.
  task automatic applyStimulus(input logic op, input logic [W-1:0] d,
                               input logic last, input int gap,
                               input logic exp_ready_after);
    int w;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("in_ready_for_token", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("in_ready_after_accept", in_ready, exp_ready_after);
  endtask

  task automatic waitResult(input int hold, input logic [W-1:0] exp_res,
                            input logic [CW-1:0] exp_cnt, output int seen_cyc);
    int w;
    out_ready = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    seen_cyc = cyc;
    checkOutput("out_valid_rise", out_valid, 1);
    checkOutput("out_result", out_result, exp_res);
    checkOutput("out_count", out_count, exp_cnt);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_result", out_result, exp_res);
      checkOutput("hold_count", out_count, exp_cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("valid_clear", out_valid, 0);
  endtask

  function automatic logic [W-1:0] refEval(input int n, input logic [7:0] ops,
                                           input logic [7:0][W-1:0] data);
    logic [W-1:0] a;
    a = data[0];
    for (int k = 1; k < n; k++)
      a = ops[k] ? W'(a - data[k]) : W'(a + data[k]);
    return a;
  endfunction

  task automatic runExpr(input int n, input logic [7:0] ops,
                         input logic [7:0][W-1:0] data, input int max_gap,
                         input int hold, input logic [W-1:0] exp_res,
                         input logic [CW-1:0] exp_cnt, output int latency);
    int start_cyc, seen, gap;
    start_cyc = cyc;
    for (int k = 0; k < n; k++) begin
      gap = (k == 0) ? 0 : int'($urandom_range(max_gap, 0));
      applyStimulus(ops[k], data[k], k == n - 1, gap, (k == 0) && (n > 1));
    end
    waitResult(hold, exp_res, exp_cnt, seen);
    latency = seen - start_cyc;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int n;
    logic [7:0] ops;
    logic [7:0][W-1:0] data;

    vecs[0] = '{2, 8'b0000_0001, {96'd0, 16'd15, 16'd15}, 1, 16'd30, 8'd2};
    vecs[1] = '{2, 8'b0000_0010, {96'd0, 16'd15, 16'd15}, 1, 16'd0, 8'd2};
    vecs[2] = '{2, 8'b0000_0000, {96'd0, 16'd1, 16'hFFFF}, 1, 16'h0000, 8'd2};
    vecs[3] = '{5, 8'b0001_0100, {48'd0, 16'd2, 16'd100, 16'd3, 16'd5, 16'd10}, 1, 16'd110, 8'd5};
    vecs[4] = '{1, 8'b0000_0000, {112'd0, 16'h1234}, 5, 16'h1234, 8'd1};
    vecs[5] = '{3, 8'b0000_0110, {80'd0, 16'd1, 16'd10, 16'd5}, 2, 16'hFFFA, 8'd3};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_result", out_result, 0);
    checkOutput("reset_out_count", out_count, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_after_release", in_ready, 1);
    @(negedge clk);

    // out_ready is left high outside DONE to show it has no effect there.
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      runExpr(vecs[i].n, vecs[i].ops, vecs[i].data, 0, vecs[i].hold,
              vecs[i].exp_res, vecs[i].exp_cnt, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, 2 * vecs[i].n - 1);
    end

    // Reset while the second operand of a 3-operand expression executes.
    applyStimulus(OP_ADD, 16'd100, 1'b0, 0, 1'b1);
    applyStimulus(OP_SUB, 16'd40, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_out_result", out_result, 0);
    checkOutput("midreset_out_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_in_ready", in_ready, 1);
    @(negedge clk);
    data = {96'd0, 16'd8, 16'd7};
    runExpr(2, 8'b0000_0000, data, 0, 1, 16'd15, 8'd2, lat);

    // Long chain saturates the counter while the sum keeps counting.
    for (int k = 0; k < 300; k++)
      applyStimulus(OP_ADD, 16'd1, k == 299, 0, k == 0);
    waitResult(1, 16'd300, 8'd255, lat);

    for (int t = 0; t < 30; t++) begin
      n   = int'($urandom_range(8, 1));
      ops = 8'($urandom);
      for (int k = 0; k < 8; k++) data[k] = W'($urandom);
      out_ready = 1'b1;
      runExpr(n, ops, data, 3, int'($urandom_range(3, 0)),
              refEval(n, ops, data), CW'(n), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
